gpfc_pause_generator: RTL and testbench

- Sources the GPFC pause interface consumed by the output-queue bypass logic: `m_axis_gpfc_valid` plus `m_axis_gpfc_pause_rank`.
- Accepts pause frames carrying a rank threshold and a duration in quanta from the downstream flow-control receiver.
- Holds the pause asserted for exactly `quanta*QUANTA_CYCLES` clocks, then releases it automatically.
- Sits between the flow-control frame parser and the root PIFO / bypass-checker stage.

---
 rtl/gpfc_pause_generator_if.sv | 25 ++
 rtl/gpfc_pause_generator.sv | 80 ++++++++
 tb/tb_gpfc_pause_generator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gpfc_pause_generator_if.sv
// Pause-frame input and GPFC pause output bundle between the frame parser,
// the pause generator and the bypass checker.
interface gpfc_pause_generator_if #(
  parameter int PIFO_RANK_WIDTH = 19,
  parameter int PIFO_ROOT_WIDTH = 32,
  parameter int QUANTA_WIDTH    = 16
);
  logic                       s_axis_pause_valid;
  logic [PIFO_RANK_WIDTH-1:0] s_axis_pause_rank;
  logic [QUANTA_WIDTH-1:0]    s_axis_pause_quanta;
  logic                       m_axis_gpfc_valid;
  logic [PIFO_ROOT_WIDTH-1:0] m_axis_gpfc_pause_rank;

  // Generator view: consumes pause frames, sources the GPFC pause.
  modport slave (
    input  s_axis_pause_valid, s_axis_pause_rank, s_axis_pause_quanta,
    output m_axis_gpfc_valid, m_axis_gpfc_pause_rank
  );

  // Environment view: sources pause frames, observes the GPFC pause.
  modport master (
    output s_axis_pause_valid, s_axis_pause_rank, s_axis_pause_quanta,
    input  m_axis_gpfc_valid, m_axis_gpfc_pause_rank
  );
endinterface

// File: rtl/gpfc_pause_generator.sv
// Holds the GPFC pause for quanta*QUANTA_CYCLES clocks after each pause frame;
// the latest frame wins, a zero-quanta frame resumes traffic at once.
module gpfc_pause_generator #(
  parameter int PIFO_RANK_WIDTH = 19,
  parameter int PIFO_ROOT_WIDTH = 32,
  parameter int QUANTA_WIDTH    = 16,
  parameter int QUANTA_CYCLES   = 64,
  parameter int EVENT_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cfg_enable,
  gpfc_pause_generator_if.slave      bus,
  output logic                       m_pause_active,
  output logic [EVENT_CNT_WIDTH-1:0] m_pause_event_cnt
);

  localparam int PRESC_W = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(QUANTA_CYCLES - 1);

  typedef enum logic {IDLE, PAUSED} state_t;

  state_t                     state_reg, state_next;
  logic [QUANTA_WIDTH-1:0]    timer_reg, timer_next;
  logic [PRESC_W-1:0]         presc_reg, presc_next;
  logic [PIFO_RANK_WIDTH-1:0] rank_reg, rank_next;
  logic [EVENT_CNT_WIDTH-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      presc_reg <= '0;
      rank_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      presc_reg <= presc_next;
      rank_reg  <= rank_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    presc_next = presc_reg;
    rank_next  = rank_reg;
    cnt_next   = cnt_reg;
    if (!cfg_enable) begin
      // Disabling abandons any pause in force; re-enabling must not resume it.
      state_next = IDLE;
      timer_next = '0;
      presc_next = '0;
    end else if (bus.s_axis_pause_valid && (bus.s_axis_pause_quanta != '0)) begin
      state_next = PAUSED;
      rank_next  = bus.s_axis_pause_rank;
      timer_next = bus.s_axis_pause_quanta;
      presc_next = '0;
      cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
    end else if (bus.s_axis_pause_valid) begin
      state_next = IDLE;
    end else if (state_reg == PAUSED) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        timer_next = timer_reg - 1'b1;
        if (timer_reg == QUANTA_WIDTH'(1)) state_next = IDLE;
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end
  end

  assign bus.m_axis_gpfc_valid      = (state_reg == PAUSED);
  assign bus.m_axis_gpfc_pause_rank = {{(PIFO_ROOT_WIDTH - PIFO_RANK_WIDTH){1'b0}}, rank_reg};
  assign m_pause_active             = (state_reg == PAUSED);
  assign m_pause_event_cnt          = cnt_reg;

endmodule

// File: tb/tb_gpfc_pause_generator.sv
// Directed bench for gpfc_pause_generator with QUANTA_CYCLES=4.
module tb_gpfc_pause_generator;

  localparam int RW = 19;
  localparam int OW = 32;
  localparam int QW = 16;
  localparam int QC = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rstn;
  logic          cfg_enable;
  logic          m_pause_active;
  logic [CW-1:0] m_pause_event_cnt;

  int checks = 0;
  int errors = 0;

  gpfc_pause_generator_if #(.PIFO_RANK_WIDTH(RW), .PIFO_ROOT_WIDTH(OW), .QUANTA_WIDTH(QW)) bus ();

  gpfc_pause_generator #(
    .PIFO_RANK_WIDTH(RW), .PIFO_ROOT_WIDTH(OW), .QUANTA_WIDTH(QW),
    .QUANTA_CYCLES(QC), .EVENT_CNT_WIDTH(CW)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_enable        (cfg_enable),
    .bus               (bus),
    .m_pause_active    (m_pause_active),
    .m_pause_event_cnt (m_pause_event_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame is presented for one cycle and accepted on the next edge.
  task automatic send(input logic [RW-1:0] rank, input logic [QW-1:0] quanta);
    $display("frame rank=0x%0h quanta=%0d", rank, quanta);
    bus.s_axis_pause_valid  = 1'b1;
    bus.s_axis_pause_rank   = rank;
    bus.s_axis_pause_quanta = quanta;
    step();
    bus.s_axis_pause_valid  = 1'b0;
  endtask

  task automatic expect_high(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(bus.m_axis_gpfc_valid), 32'd1);
      step();
    end
  endtask

  initial begin
    rstn                    = 1'b0;
    cfg_enable              = 1'b0;
    bus.s_axis_pause_valid  = 1'b0;
    bus.s_axis_pause_rank   = '0;
    bus.s_axis_pause_quanta = '0;
    step();
    step();
    check("reset_valid",  32'(bus.m_axis_gpfc_valid), 32'd0);
    check("reset_rank",   bus.m_axis_gpfc_pause_rank, 32'd0);
    check("reset_active", 32'(m_pause_active), 32'd0);
    check("reset_cnt",    32'(m_pause_event_cnt), 32'd0);
    rstn       = 1'b1;
    cfg_enable = 1'b1;
    step();

    // Basic pause: 3 quanta * 4 cycles = 12 cycles high.
    send(19'h100, 16'd3);
    check("basic_rank",   bus.m_axis_gpfc_pause_rank, 32'h0000_0100);
    check("basic_active", 32'(m_pause_active), 32'd1);
    check("basic_cnt",    32'(m_pause_event_cnt), 32'd1);
    expect_high("basic_valid", 12);
    check("basic_expired", 32'(bus.m_axis_gpfc_valid), 32'd0);
    step();

    // Override five cycles in: new 2-quanta pause restarts, 8 cycles high.
    send(19'h100, 16'd3);
    expect_high("ovr_pre_valid", 4);
    send(19'h050, 16'd2);
    check("ovr_rank", bus.m_axis_gpfc_pause_rank, 32'h0000_0050);
    check("ovr_cnt",  32'(m_pause_event_cnt), 32'd3);
    expect_high("ovr_valid", 8);
    check("ovr_expired", 32'(bus.m_axis_gpfc_valid), 32'd0);
    step();

    // Resume frame mid-pause, then a resume frame while idle.
    send(19'h100, 16'd3);
    expect_high("resume_pre_valid", 3);
    send(19'h077, 16'd0);
    check("resume_valid", 32'(bus.m_axis_gpfc_valid), 32'd0);
    check("resume_cnt",   32'(m_pause_event_cnt), 32'd4);
    send(19'h033, 16'd0);
    check("idle_zero_valid", 32'(bus.m_axis_gpfc_valid), 32'd0);
    check("idle_zero_cnt",   32'(m_pause_event_cnt), 32'd4);
    step();

    // Frame on the natural expiry edge keeps the pause up without a gap.
    send(19'h100, 16'd3);
    expect_high("expiry_pre_valid", 11);
    send(19'h020, 16'd1);
    check("expiry_rank", bus.m_axis_gpfc_pause_rank, 32'h0000_0020);
    check("expiry_cnt",  32'(m_pause_event_cnt), 32'd6);
    expect_high("expiry_valid", 4);
    check("expiry_expired", 32'(bus.m_axis_gpfc_valid), 32'd0);
    step();

    // Disable mid-pause; frames while disabled are dropped; re-enable stays idle.
    send(19'h100, 16'd3);
    step();
    cfg_enable = 1'b0;
    step();
    check("dis_valid", 32'(bus.m_axis_gpfc_valid), 32'd0);
    send(19'h044, 16'd5);
    check("dis_frame_valid", 32'(bus.m_axis_gpfc_valid), 32'd0);
    check("dis_frame_cnt",   32'(m_pause_event_cnt), 32'd7);
    cfg_enable = 1'b1;
    step();
    step();
    step();
    check("reen_valid", 32'(bus.m_axis_gpfc_valid), 32'd0);
    check("reen_cnt",   32'(m_pause_event_cnt), 32'd7);

    // Asynchronous reset mid-pause clears outputs before any clock edge.
    send(19'h100, 16'd3);
    step();
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid",  32'(bus.m_axis_gpfc_valid), 32'd0);
    check("arst_rank",   bus.m_axis_gpfc_pause_rank, 32'd0);
    check("arst_active", 32'(m_pause_active), 32'd0);
    check("arst_cnt",    32'(m_pause_event_cnt), 32'd0);
    step();
    rstn = 1'b1;
    step();

    // Counter saturation: 2^16+5 back-to-back accepted frames.
    $display("frame burst of 65541 frames rank=0x1 quanta=1");
    bus.s_axis_pause_valid  = 1'b1;
    bus.s_axis_pause_rank   = 19'h1;
    bus.s_axis_pause_quanta = 16'd1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_below", 32'(m_pause_event_cnt), 32'h0000_FFFE);
    repeat (7) @(posedge clk);
    #1;
    bus.s_axis_pause_valid = 1'b0;
    check("sat_cnt", 32'(m_pause_event_cnt), 32'h0000_FFFF);
    check("sat_valid", 32'(bus.m_axis_gpfc_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
